// File: rtl/nibble_par_pkg.sv
// Shared types and constants for the nibble parity checking stage.
package nibble_par_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_PAR = 2'd2,
        REPORT   = 2'd3
    } state_t;

    // States in which the stage is willing to take a nibble.
    function automatic logic accepts_data(input state_t s);
        return (s == IDLE) || (s == ACCUM);
    endfunction

endpackage

// File: rtl/nibble_xor4.sv
// Four-input XOR gate; the parity primitive this stage consumes.
module nibble_xor4 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_y
);

    assign o_y = i_a ^ i_b ^ i_c ^ i_d;

endmodule

// File: rtl/nibble_parity_checker.sv
// Frame parity checker: XOR-reduces accepted nibbles, accumulates parity over
// FRAME_LEN nibbles, compares with a separately delivered parity bit, and
// keeps a saturating count of mismatched frames.
module nibble_parity_checker
    import nibble_par_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NIB_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sof,
    input  logic             par_in,
    input  logic             par_valid,
    output logic             nib_par,
    output logic             done,
    output logic             par_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int                  CNT_BITS = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(FRAME_LEN);
    // A one-nibble frame is complete as soon as its sof nibble is taken.
    localparam bit                  SINGLE   = (FRAME_LEN == 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_din_ready;
    logic                r_acc;
    logic                r_nib_par;
    logic                r_mismatch;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_nib_xor;
    logic                w_accept;
    logic                w_ready_next;
    logic                w_done;
    logic                w_cnt_hit;
    logic [CNT_BITS-1:0] w_cnt_inc;

    nibble_xor4 u_xor4 (
        .i_a (din[3]),
        .i_b (din[2]),
        .i_c (din[1]),
        .i_d (din[0]),
        .o_y (w_nib_xor)
    );

    assign w_accept  = din_valid & r_din_ready;
    assign w_cnt_inc = r_cnt + CNT_BITS'(1);
    assign w_cnt_hit = (w_cnt_inc == LAST_CNT);

    // State register; din_ready is registered from the next state so it is a
    // clean Moore output that first rises on the edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_din_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_din_ready <= w_ready_next;
        end
    end

    // Next-state logic: sof always (re)starts a frame, even mid-frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && sof) begin
                    w_state_next = SINGLE ? WAIT_PAR : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (sof) begin
                        w_state_next = SINGLE ? WAIT_PAR : ACCUM;
                    end else if (w_cnt_hit) begin
                        w_state_next = WAIT_PAR;
                    end
                end
            end
            WAIT_PAR: begin
                if (par_valid) begin
                    w_state_next = REPORT;
                end
            end
            REPORT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output decode: ready follows the next state, done/par_err only in REPORT.
    always_comb begin
        w_ready_next = accepts_data(w_state_next);
        w_done       = (r_state == REPORT);
    end

    // Datapath: nibble parity, frame accumulator, verdict and error counter.
    // The error count advances on the edge that ends REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib_par  <= 1'b0;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_nib_par <= w_nib_xor;
            end
            if (w_accept && sof) begin
                r_acc <= w_nib_xor;
                r_cnt <= CNT_BITS'(1);
            end else if (w_accept && (r_state == ACCUM)) begin
                r_acc <= r_acc ^ w_nib_xor;
                r_cnt <= w_cnt_inc;
            end
            if ((r_state == WAIT_PAR) && par_valid) begin
                r_mismatch <= r_acc ^ par_in;
            end
            if ((r_state == REPORT) && r_mismatch && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign din_ready = r_din_ready;
    assign nib_par   = r_nib_par;
    assign done      = w_done;
    assign par_err   = w_done & r_mismatch;
    assign err_cnt   = r_err_cnt;

endmodule
